pp_colorconv_pipe: RTL and testbench

//  Parametrised pixel preprocessor between the camera capture FIFO and the frame buffer.

---
 rtl/pp_pkg.sv | 17 +
 rtl/pp_ch_expand.sv | 16 +
 rtl/pp_colorconv_pipe.sv | 134 +++++++++++++
 tb/tb_pp_colorconv_pipe.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pp_pkg.sv
// Shared constants for the pixel preprocessor: mode codes, luma weights and rounding offset.
package pp_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_PASS   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_GREY   = 2'd1;
    localparam logic [MODE_W-1:0] MODE_THRESH = 2'd2;
    localparam logic [MODE_W-1:0] MODE_INV    = 2'd3;

    // Luma weights sum to 256, so the weighted sum >> 8 always fits in 8 bits
    localparam logic [7:0]  KR    = 8'd77;
    localparam logic [7:0]  KG    = 8'd150;
    localparam logic [7:0]  KB    = 8'd29;
    localparam logic [16:0] ROUND = 17'd128;

endpackage

// File: rtl/pp_ch_expand.sv
// Widens one CH_W-bit colour channel to 8 bits by repeating its bits from the MSB down.
module pp_ch_expand #(
    parameter int unsigned CH_W = 4
) (
    input  logic [CH_W-1:0] c,
    output logic [7:0]      c8
);

    always_comb begin
        c8 = '0;
        for (int i = 0; i < 8; i++) begin
            c8[7-i] = c[CH_W-1-(i%CH_W)];
        end
    end

endmodule

// File: rtl/pp_colorconv_pipe.sv
// Three-stage RGB preprocessor (expand, weight, sum/quantise) with valid/ready backpressure
// and a mode register that only changes on an accepted start-of-frame beat.
module pp_colorconv_pipe
    import pp_pkg::*;
#(
    parameter int unsigned CH_W   = 4,
    parameter int unsigned THRESH = 128
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [3*CH_W-1:0]   i_data,
    input  logic                i_sof,
    input  logic [MODE_W-1:0]   i_mode,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [3*CH_W-1:0]   o_data,
    output logic                o_sof,
    output logic [MODE_W-1:0]   o_mode
);

    localparam int unsigned PIX_W = 3 * CH_W;
    localparam int unsigned SHIFT = 8 - CH_W;
    localparam int unsigned RND   = 128 >> CH_W;
    localparam logic [CH_W-1:0] QMAX = '1;

    logic              ld1, ld2, ld3, in_fire;
    logic [MODE_W-1:0] active_mode, in_mode;

    logic              v1, s1_sof;
    logic [7:0]        s1_r8, s1_g8, s1_b8;
    logic [PIX_W-1:0]  s1_raw;
    logic [MODE_W-1:0] s1_mode;

    logic              v2, s2_sof;
    logic [15:0]       s2_pr, s2_pg, s2_pb;
    logic [PIX_W-1:0]  s2_raw;
    logic [MODE_W-1:0] s2_mode;

    logic [7:0]        r8_c, g8_c, b8_c;
    logic [16:0]       sum_c;
    logic [7:0]        y8_c;
    logic [8:0]        yr_c, ysh_c;
    logic [CH_W-1:0]   yq_c;
    logic [PIX_W-1:0]  res_c;

    // Ready chain: a stage loads when it is empty or its successor is moving
    assign ld3     = !o_valid || i_ready;
    assign ld2     = !v2 || ld3;
    assign ld1     = !v1 || ld2;
    assign o_ready = ld1;
    assign in_fire = i_valid && ld1;
    assign in_mode = i_sof ? i_mode : active_mode;

    pp_ch_expand #(.CH_W(CH_W)) u_exp_r (.c(i_data[PIX_W-1 -: CH_W]),  .c8(r8_c));
    pp_ch_expand #(.CH_W(CH_W)) u_exp_g (.c(i_data[2*CH_W-1 -: CH_W]), .c8(g8_c));
    pp_ch_expand #(.CH_W(CH_W)) u_exp_b (.c(i_data[CH_W-1:0]),         .c8(b8_c));

    // Luma sum, rounding requantise to CH_W with saturation, then per-mode output select
    always_comb begin
        sum_c = 17'(s2_pr) + 17'(s2_pg) + 17'(s2_pb) + ROUND;
        y8_c  = 8'(sum_c >> 8);
        yr_c  = 9'(y8_c) + 9'(RND);
        ysh_c = yr_c >> SHIFT;
        yq_c  = (ysh_c > 9'(QMAX)) ? QMAX : CH_W'(ysh_c);
        res_c = s2_raw;
        case (s2_mode)
            MODE_GREY:   res_c = {3{yq_c}};
            MODE_THRESH: res_c = (y8_c >= 8'(THRESH)) ? '1 : '0;
            MODE_INV:    res_c = {3{~yq_c}};
            default:     res_c = s2_raw;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            active_mode <= MODE_PASS;
            v1          <= 1'b0;
            s1_sof      <= 1'b0;
            s1_r8       <= '0;
            s1_g8       <= '0;
            s1_b8       <= '0;
            s1_raw      <= '0;
            s1_mode     <= MODE_PASS;
            v2          <= 1'b0;
            s2_sof      <= 1'b0;
            s2_pr       <= '0;
            s2_pg       <= '0;
            s2_pb       <= '0;
            s2_raw      <= '0;
            s2_mode     <= MODE_PASS;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_sof       <= 1'b0;
            o_mode      <= MODE_PASS;
        end else begin
            if (in_fire && i_sof) begin
                active_mode <= i_mode;
            end
            if (ld1) begin
                v1 <= i_valid;
                if (i_valid) begin
                    s1_r8   <= r8_c;
                    s1_g8   <= g8_c;
                    s1_b8   <= b8_c;
                    s1_raw  <= i_data;
                    s1_sof  <= i_sof;
                    s1_mode <= in_mode;
                end
            end
            if (ld2) begin
                v2 <= v1;
                if (v1) begin
                    s2_pr   <= 16'(KR) * 16'(s1_r8);
                    s2_pg   <= 16'(KG) * 16'(s1_g8);
                    s2_pb   <= 16'(KB) * 16'(s1_b8);
                    s2_raw  <= s1_raw;
                    s2_sof  <= s1_sof;
                    s2_mode <= s1_mode;
                end
            end
            if (ld3) begin
                o_valid <= v2;
                if (v2) begin
                    o_data <= res_c;
                    o_sof  <= s2_sof;
                    o_mode <= s2_mode;
                end
            end
        end
    end

endmodule

// File: tb/tb_pp_colorconv_pipe.sv
// Self-checking bench for pp_colorconv_pipe (CH_W=4, THRESH=128) against an arithmetic luma model.
module tb_pp_colorconv_pipe;

    logic        i_clk = 1'b0;
    logic        i_rstn, i_valid, o_ready, i_sof, o_valid, i_ready, o_sof;
    logic [11:0] i_data, o_data;
    logic [1:0]  i_mode, o_mode;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [11:0] data;
        logic        sof;
        logic [1:0]  mode;
    } exp_t;

    exp_t       q[$];
    logic [1:0] mdl_mode = 2'd0;

    pp_colorconv_pipe #(.CH_W(4), .THRESH(128)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_sof(i_sof), .i_mode(i_mode), .o_valid(o_valid),
        .i_ready(i_ready), .o_data(o_data), .o_sof(o_sof), .o_mode(o_mode)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [11:0] ref_pixel(input logic [11:0] d, input logic [1:0] m);
        int r8, g8, b8, y8, yq;
        r8 = int'(d[11:8]) * 17;
        g8 = int'(d[7:4]) * 17;
        b8 = int'(d[3:0]) * 17;
        y8 = (77 * r8 + 150 * g8 + 29 * b8 + 128) / 256;
        yq = (y8 + 8) / 16;
        if (yq > 15) yq = 15;
        case (m)
            2'd0:    return d;
            2'd1:    return 12'(yq * 273);
            2'd2:    return (y8 >= 128) ? 12'hFFF : 12'h000;
            default: return 12'((15 - yq) * 273);
        endcase
    endfunction

    task automatic push_beat(input logic [11:0] d, input logic s, input logic [1:0] m);
        exp_t e;
        if (s) mdl_mode = m;
        e.data = ref_pixel(d, mdl_mode);
        e.sof  = s;
        e.mode = mdl_mode;
        q.push_back(e);
    endtask

    // Drive one cycle's inputs at the falling edge, report which handshakes fire at the next rise
    task automatic step(input logic v, input logic [11:0] d, input logic s, input logic [1:0] m,
                        input logic r, output logic acc, output logic fire);
        @(negedge i_clk);
        i_valid = v; i_data = d; i_sof = s; i_mode = m; i_ready = r;
        #1;
        acc  = v && o_ready;
        fire = o_valid && r;
    endtask

    task automatic test_reset();
        i_rstn = 1'b0; i_valid = 1'b0; i_data = '0; i_sof = 1'b0; i_mode = 2'd0; i_ready = 1'b1;
        repeat (2) @(negedge i_clk);
        #1;
        checks++;
        if ({o_valid, o_data, o_sof, o_mode} !== 16'h0) $display("FAIL reset_outputs: got %h expected 0000", {o_valid, o_data, o_sof, o_mode});
        else passes++;
        checks++;
        if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", o_ready);
        else passes++;
        @(negedge i_clk);
        i_rstn = 1'b1;
    endtask

    task automatic test_directed();
        logic [11:0] px[11] = '{12'hFFF, 12'hF00, 12'h0F0, 12'h00F, 12'h000,
                                12'hF00, 12'h0F0, 12'hFFF, 12'hA5C, 12'h0F0, 12'h0F0};
        logic        sf[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0]  md[11] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd1};
        logic [11:0] ex[11] = '{12'hFFF, 12'h555, 12'h999, 12'h222, 12'h000,
                                12'h000, 12'hFFF, 12'h000, 12'hA5C, 12'h0F0, 12'h999};
        logic [1:0]  em[11] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1};
        logic acc, fire;
        for (int i = 0; i < 11; i++) begin
            step(1'b1, px[i], sf[i], md[i], 1'b1, acc, fire);
            checks++;
            if (acc !== 1'b1) $display("FAIL dir_accept[%0d]: got %b expected 1", i, acc);
            else passes++;
            if (acc) push_beat(px[i], sf[i], md[i]);
            step(1'b0, 12'h0, 1'b0, 2'd0, 1'b1, acc, fire);
            step(1'b0, 12'h0, 1'b0, 2'd0, 1'b1, acc, fire);
            checks++;
            if (o_valid !== 1'b0) $display("FAIL dir_early[%0d]: got o_valid %b expected 0", i, o_valid);
            else passes++;
            step(1'b0, 12'h0, 1'b0, 2'd0, 1'b1, acc, fire);
            checks++;
            if ({o_valid, o_data, o_sof, o_mode} !== {1'b1, ex[i], sf[i], em[i]})
                $display("FAIL dir_out[%0d]: got v%b d%h s%b m%0d expected v1 d%h s%b m%0d",
                         i, o_valid, o_data, o_sof, o_mode, ex[i], sf[i], em[i]);
            else passes++;
            if (fire && q.size() > 0) void'(q.pop_front());
        end
    endtask

    task automatic test_stream(input int n, input bit stall, input bit gaps);
        logic        have_p = 1'b0, ps = 1'b0, acc, fire, r, held = 1'b0, prev_sof = 1'b0;
        logic [11:0] pd = '0, prev_d = '0;
        logic [1:0]  pm = '0;
        int          sent = 0, got = 0, cyc = 0, pre, st0;
        bit          ahist[$];
        exp_t        e;
        st0 = int'($urandom_range(3, 8));
        while (got < n && cyc < 400) begin
            if (!have_p && sent < n && (!gaps || $urandom_range(0, 2) != 0)) begin
                pd = 12'($urandom); pm = 2'($urandom);
                ps = (sent == 0) || ($urandom_range(0, 3) == 0);
                have_p = 1'b1;
            end
            r   = !(stall && cyc >= st0 && cyc < st0 + 5);
            pre = q.size();
            step(have_p, pd, ps, pm, r, acc, fire);
            checks++;
            if (o_ready !== ((pre < 3) || r)) $display("FAIL stream_ready c%0d: got %b expected %b", cyc, o_ready, (pre < 3) || r);
            else passes++;
            if (held) begin
                checks++;
                if ({o_valid, o_data, o_sof} !== {1'b1, prev_d, prev_sof})
                    $display("FAIL stream_hold c%0d: got v%b d%h expected v1 d%h", cyc, o_valid, o_data, prev_d);
                else passes++;
            end
            held = o_valid && !r; prev_d = o_data; prev_sof = o_sof;
            if (!stall) begin
                checks++;
                if (o_valid !== ((cyc >= 3) ? ahist[cyc-3] : 1'b0))
                    $display("FAIL stream_rate c%0d: got o_valid %b expected %b", cyc, o_valid, (cyc >= 3) ? ahist[cyc-3] : 1'b0);
                else passes++;
            end
            ahist.push_back(acc);
            if (fire) begin
                checks++;
                if (q.size() == 0) $display("FAIL stream_dup c%0d: got output %h expected none", cyc, o_data);
                else begin
                    e = q.pop_front();
                    if ({o_data, o_sof, o_mode} !== {e.data, e.sof, e.mode})
                        $display("FAIL stream_data c%0d: got d%h s%b m%0d expected d%h s%b m%0d",
                                 cyc, o_data, o_sof, o_mode, e.data, e.sof, e.mode);
                    else passes++;
                end
                got++;
            end
            if (acc) begin push_beat(pd, ps, pm); sent++; have_p = 1'b0; end
            cyc++;
        end
        checks++;
        if (got !== n || q.size() != 0) $display("FAIL stream_count: got %0d outputs expected %0d (left %0d)", got, n, q.size());
        else passes++;
    endtask

    task automatic test_reset_midflight();
        logic        acc, fire;
        logic [11:0] d;
        exp_t        e;
        bit          done = 0;
        for (int k = 0; k < 3; k++) begin
            d = 12'($urandom);
            step(1'b1, d, k == 0, 2'd1, 1'b0, acc, fire);
            checks++;
            if (acc !== 1'b1) $display("FAIL rst_fill[%0d]: got %b expected 1", k, acc);
            else passes++;
            if (acc) push_beat(d, k == 0, 2'd1);
        end
        step(1'b0, 12'h0, 1'b0, 2'd0, 1'b0, acc, fire);
        checks++;
        if ({o_valid, o_ready, o_mode} !== {1'b1, 1'b0, 2'd1}) $display("FAIL rst_full: got v%b r%b m%0d expected v1 r0 m1", o_valid, o_ready, o_mode);
        else passes++;
        i_rstn = 1'b0;
        step(1'b0, 12'h0, 1'b0, 2'd0, 1'b1, acc, fire);
        checks++;
        if ({o_valid, o_mode, o_data, o_sof} !== 16'h0) $display("FAIL rst_flush: got v%b m%0d d%h expected v0 m0 d000", o_valid, o_mode, o_data);
        else passes++;
        q.delete();
        mdl_mode = 2'd0;
        i_rstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 12'h0, 1'b0, 2'd0, 1'b1, acc, fire);
            checks++;
            if (o_valid !== 1'b0) $display("FAIL rst_stale[%0d]: got o_valid %b expected 0", k, o_valid);
            else passes++;
        end
        step(1'b1, 12'h0F0, 1'b0, 2'd2, 1'b1, acc, fire);
        if (acc) push_beat(12'h0F0, 1'b0, 2'd2);
        for (int k = 0; k < 8 && !done; k++) begin
            step(1'b0, 12'h0, 1'b0, 2'd0, 1'b1, acc, fire);
            if (fire && q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({o_data, o_mode} !== {e.data, e.mode}) $display("FAIL rst_mode: got d%h m%0d expected d%h m%0d", o_data, o_mode, e.data, e.mode);
                else passes++;
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            $display("FAIL rst_timeout: got no output expected one beat");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream(10, 1'b1, 1'b0);
        test_stream(10, 1'b1, 1'b0);
        test_stream(40, 1'b0, 1'b1);
        test_reset_midflight();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
